// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl_pkg: shared state encoding and wake-counter width for the clock-gating controller
package clk_gate_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;
    localparam int WAKE_W = 4;
endpackage

// File: rtl/clk_gate_chan.sv
// clk_gate_chan: one gated domain -- OFF/WAKE/ON/DRAIN FSM with wake-settle and idle counters
// Ports: CLK, RSTN (async active-low), act (request), IDLE_LIMIT (live threshold),
//        SCAN_MODE (freeze, only with CLK_GATE_CTRL_SCAN_EN), GATE_E / ACK / GATED (registered)
import clk_gate_ctrl_pkg::*;
module clk_gate_chan #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              act,
    input  logic [IDLE_W-1:0] IDLE_LIMIT,
`ifdef CLK_GATE_CTRL_SCAN_EN
    input  logic              SCAN_MODE,
`endif
    output logic              GATE_E,
    output logic              ACK,
    output logic              GATED
);
    state_t            st, st_n;
    logic [WAKE_W-1:0] wcnt, wcnt_n;
    logic [IDLE_W-1:0] cnt, cnt_n;
    always_comb begin
        st_n   = st;
        wcnt_n = wcnt;
        cnt_n  = cnt;
        case (st)
            ST_OFF: if (act) begin
                st_n   = ST_WAKE;
                wcnt_n = WAKE_W'(WAKE_CYC - 1);
            end
            ST_WAKE: if (wcnt == '0) begin
                st_n  = ST_ON;
                cnt_n = '0;
            end else wcnt_n = wcnt - 1'b1;
            // >= rather than == so a limit lowered below cnt drains at the next idle edge,
            // and cnt saturates because the compare fires before any wrap
            ST_ON: if (act) cnt_n = '0;
                   else if (cnt >= IDLE_LIMIT) st_n = ST_DRAIN;
                   else cnt_n = cnt + 1'b1;
            ST_DRAIN: begin
                st_n  = act ? ST_ON : ST_OFF;
                cnt_n = '0;
            end
            default: st_n = ST_OFF;
        endcase
`ifdef CLK_GATE_CTRL_SCAN_EN
        if (SCAN_MODE) begin
            st_n   = st;
            wcnt_n = wcnt;
            cnt_n  = cnt;
        end
`endif
    end
    // Outputs are flops decoded from the next state so GATE_E reaches the latch glitch-free
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            st     <= ST_OFF;
            wcnt   <= '0;
            cnt    <= '0;
            GATE_E <= 1'b0;
            ACK    <= 1'b0;
            GATED  <= 1'b1;
        end else begin
            st     <= st_n;
            wcnt   <= wcnt_n;
            cnt    <= cnt_n;
            GATE_E <= st_n != ST_OFF;
            ACK    <= st_n == ST_ON;
            GATED  <= st_n == ST_OFF;
        end
    end
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-domain clock-gate enable controller for a bank of latch-based gate cells
// Ports: CLK, RSTN (async active-low), REQ / FORCE_ON (per-domain activity), IDLE_LIMIT,
//        SCAN_MODE (only with CLK_GATE_CTRL_SCAN_EN: forces GATE_E high, freezes FSMs),
//        GATE_E / ACK / GATED (per domain)
import clk_gate_ctrl_pkg::*;
module clk_gate_ctrl #(
    parameter int N_DOM    = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
`ifdef CLK_GATE_CTRL_SCAN_EN
    input  logic              SCAN_MODE,
`endif
    input  logic [N_DOM-1:0]  REQ,
    input  logic [N_DOM-1:0]  FORCE_ON,
    input  logic [IDLE_W-1:0] IDLE_LIMIT,
    output logic [N_DOM-1:0]  GATE_E,
    output logic [N_DOM-1:0]  ACK,
    output logic [N_DOM-1:0]  GATED
);
    logic [N_DOM-1:0] ge;
    for (genvar g = 0; g < N_DOM; g++) begin : g_chan
        clk_gate_chan #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) u_chan (
            .CLK        (CLK),
            .RSTN       (RSTN),
            .act        (REQ[g] | FORCE_ON[g]),
            .IDLE_LIMIT (IDLE_LIMIT),
`ifdef CLK_GATE_CTRL_SCAN_EN
            .SCAN_MODE  (SCAN_MODE),
`endif
            .GATE_E     (ge[g]),
            .ACK        (ACK[g]),
            .GATED      (GATED[g])
        );
    end
`ifdef CLK_GATE_CTRL_SCAN_EN
    assign GATE_E = ge | {N_DOM{SCAN_MODE}};
`else
    assign GATE_E = ge;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: randomized scoreboard bench for clk_gate_ctrl against a behavioural model
module tb_clk_gate_ctrl;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int WC = 2;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] FORCE_ON = '0;
    logic [W-1:0] IDLE_LIMIT = '0;
    logic [N-1:0] GATE_E, ACK, GATED;
`ifdef CLK_GATE_CTRL_SCAN_EN
    logic         SCAN_MODE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0] ge;
        logic [N-1:0] ack;
        logic [N-1:0] gated;
    } exp_t;
    exp_t q[$];

    // Model: a domain is asleep, or awake with some settle edges still to go,
    // or running and counting consecutive idle samples, or in its one drain cycle.
    bit asleep[N];
    int settle[N];
    int lows[N];
    bit drain[N];

    clk_gate_ctrl #(.N_DOM(N), .IDLE_W(W), .WAKE_CYC(WC)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
`ifdef CLK_GATE_CTRL_SCAN_EN
        .SCAN_MODE  (SCAN_MODE),
`endif
        .REQ        (REQ),
        .FORCE_ON   (FORCE_ON),
        .IDLE_LIMIT (IDLE_LIMIT),
        .GATE_E     (GATE_E),
        .ACK        (ACK),
        .GATED      (GATED)
    );

    always #5 CLK = ~CLK;

    function void model_reset();
        for (int i = 0; i < N; i++) begin
            asleep[i] = 1'b1;
            settle[i] = 0;
            lows[i]   = 0;
            drain[i]  = 1'b0;
        end
    endfunction

    function void model_edge(logic [N-1:0] a, int lim);
        for (int i = 0; i < N; i++) begin
            if (asleep[i]) begin
                if (a[i]) begin
                    asleep[i] = 1'b0;
                    settle[i] = WC;
                end
            end else if (settle[i] > 0) begin
                settle[i]--;
                lows[i] = 0;
            end else if (drain[i]) begin
                drain[i] = 1'b0;
                if (a[i]) lows[i] = 0;
                else asleep[i] = 1'b1;
            end else if (a[i]) lows[i] = 0;
            else if (lows[i] >= lim) drain[i] = 1'b1;
            else lows[i]++;
        end
    endfunction

    function exp_t model_out();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.ge[i]    = !asleep[i];
            e.ack[i]   = !asleep[i] && settle[i] == 0 && !drain[i];
            e.gated[i] = asleep[i];
        end
        return e;
    endfunction

    function void check(string name, logic [N-1:0] got, logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
        end
    endfunction

    // Monitor: outputs are presented every cycle, compare after each edge
    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("gate_e", GATE_E, e.ge);
            check("ack", ACK, e.ack);
            check("gated", GATED, e.gated);
        end
    end

    task automatic step(logic [N-1:0] req, logic [N-1:0] frc, int lim);
        @(negedge CLK);
        RSTN = 1'b1;
        REQ = req;
        FORCE_ON = frc;
        IDLE_LIMIT = W'(lim);
        model_edge(req | frc, lim);
        q.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        REQ = '1;
        #1;
        q.delete();
        model_reset();
        check("rst_gate_e_async", GATE_E, '0);
        check("rst_ack_async", ACK, '0);
        check("rst_gated_async", GATED, '1);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_gate_e", GATE_E, '0);
        check("rst_ack", ACK, '0);
        check("rst_gated", GATED, '1);
    endtask

    function logic [N-1:0] rnd_bits(int pct);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = $urandom_range(0, 99) < pct;
        return b;
    endfunction

    initial begin
        model_reset();
        do_reset();
        step('1, '0, 0);
        step('0, '0, 0);
        repeat (4) step('0, '0, 0);
        // single-cycle pulse on domain 0, limit 0
        step(4'b0001, '0, 0);
        repeat (5) step('0, '0, 0);
        // idle limit 3 on domain 1 with a blip at the 3rd low sample
        step(4'b0010, '0, 3);
        repeat (3) step(4'b0010, '0, 3);
        repeat (2) step('0, '0, 3);
        step(4'b0010, '0, 3);
        repeat (7) step('0, '0, 3);
        // drain re-entry on domain 2
        repeat (4) step(4'b0100, '0, 0);
        step('0, '0, 0);
        step(4'b0100, '0, 0);
        step(4'b0100, '0, 0);
        repeat (4) step('0, '0, 0);
        // live limit lowered below the running idle count
        repeat (4) step(4'b1000, '0, 20);
        repeat (11) step('0, '0, 20);
        repeat (4) step('0, '0, 5);
        // counter saturation at the maximum limit
        repeat (4) step(4'b0001, '0, 255);
        repeat (262) step('0, '0, 255);
        // randomized phases
        for (int p = 0; p < 8; p++) begin
            int lim;
            lim = (p % 3 == 0) ? 0 : $urandom_range(0, 6);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 19) == 0) lim = $urandom_range(0, 6);
                step(rnd_bits(p * 8 + 10), rnd_bits(3), lim);
            end
            if (p == 4) begin
                do_reset();
                step('0, '0, 0);
            end
        end
`ifdef CLK_GATE_CTRL_SCAN_EN
        do_reset();
        step('0, '0, 0);
        @(negedge CLK);
        SCAN_MODE = 1'b1;
        REQ = '1;
        #1;
        check("scan_gate_e", GATE_E, '1);
        repeat (3) @(posedge CLK);
        #1;
        check("scan_gated_hold", GATED, '1);
        check("scan_ack_hold", ACK, '0);
        @(negedge CLK);
        SCAN_MODE = 1'b0;
        REQ = '0;
        #1;
        check("scan_release", GATE_E, '0);
        step('1, '0, 0);
        repeat (4) step('0, '0, 0);
`endif
        repeat (2) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
